// File: rtl/output_mems.sv
// output_mems: result buffer plus AXI-Stream transmitter.
// The compute unit fills a DEPTH x OUTW RAM by address. compute_done starts a
// row-major drain of every address over AXIS, with TLAST on the final element.
// Optional feature macro OUTPUT_ROW_TUSER_EN adds AXIS_TUSER, which flags the
// last column of each row.
module output_mems #(
    parameter int unsigned OUTW = 27,
    parameter int unsigned M    = 7,
    parameter int unsigned N    = 9,
    localparam int unsigned DEPTH       = M * N,
    localparam int unsigned C_ADDR_BITS = $clog2(M * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OUTW-1:0]        C_data,
    input  logic [C_ADDR_BITS-1:0] C_addr,
    input  logic                   C_wr_en,
    input  logic                   compute_done,
    output logic                   out_mem_ready,
    output logic [OUTW-1:0]        AXIS_TDATA,
    output logic                   AXIS_TVALID,
`ifdef OUTPUT_ROW_TUSER_EN
    output logic                   AXIS_TUSER,
`endif
    input  logic                   AXIS_TREADY,
    output logic                   AXIS_TLAST
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                 state;
    logic [OUTW-1:0]        mem [DEPTH];
    logic [C_ADDR_BITS-1:0] rd_cnt;
    logic [C_ADDR_BITS-1:0] snd_cnt;
    logic                   rd_done;
    logic [OUTW-1:0]        sk_data;
    logic                   sk_last;
    logic                   sk_valid;

    logic                   pop_c;
    logic                   rd_en_c;
    logic                   rd_last_c;
    logic [OUTW-1:0]        rd_data_c;

`ifdef OUTPUT_ROW_TUSER_EN
    localparam int unsigned COL_BITS = (N > 1) ? $clog2(N) : 1;
    logic [COL_BITS-1:0]    rd_col;
    logic                   sk_user;
    logic                   rd_user_c;

    assign rd_user_c = (rd_col == COL_BITS'(N - 1));
`endif

    // A read is issued only when the skid entry is free, so the read enable
    // depends on registers alone and never on AXIS_TREADY.
    assign pop_c     = AXIS_TVALID && AXIS_TREADY;
    assign rd_en_c   = (state == DRAIN) && !rd_done && !sk_valid;
    assign rd_last_c = (rd_cnt == C_ADDR_BITS'(DEPTH - 1));
    assign rd_data_c = mem[rd_cnt];

    // Result RAM write port: only while collecting, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (!reset && (state == COLLECT) && C_wr_en && (32'(C_addr) < DEPTH))
            mem[C_addr] <= C_data;
    end

    // Control FSM, read counter, two-entry output/skid buffer and send counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            out_mem_ready <= 1'b1;
            AXIS_TVALID   <= 1'b0;
            AXIS_TLAST    <= 1'b0;
            AXIS_TDATA    <= '0;
            rd_cnt        <= '0;
            snd_cnt       <= '0;
            rd_done       <= 1'b0;
            sk_valid      <= 1'b0;
            sk_data       <= '0;
            sk_last       <= 1'b0;
`ifdef OUTPUT_ROW_TUSER_EN
            AXIS_TUSER    <= 1'b0;
            sk_user       <= 1'b0;
            rd_col        <= '0;
`endif
        end else if (state == COLLECT) begin
            if (compute_done) begin
                state         <= DRAIN;
                out_mem_ready <= 1'b0;
                rd_cnt        <= '0;
                snd_cnt       <= '0;
                rd_done       <= 1'b0;
`ifdef OUTPUT_ROW_TUSER_EN
                rd_col        <= '0;
`endif
            end
        end else begin
            if (rd_en_c) begin
                if (rd_last_c)
                    rd_done <= 1'b1;
                else
                    rd_cnt <= rd_cnt + C_ADDR_BITS'(1);
`ifdef OUTPUT_ROW_TUSER_EN
                rd_col <= rd_user_c ? '0 : rd_col + COL_BITS'(1);
`endif
            end

            if (!AXIS_TVALID || pop_c) begin
                // Head is empty or leaving: refill from skid first, then from RAM.
                if (AXIS_TVALID && sk_valid) begin
                    AXIS_TDATA <= sk_data;
                    AXIS_TLAST <= sk_last;
                    sk_valid   <= 1'b0;
`ifdef OUTPUT_ROW_TUSER_EN
                    AXIS_TUSER <= sk_user;
`endif
                end else if (rd_en_c) begin
                    AXIS_TDATA  <= rd_data_c;
                    AXIS_TLAST  <= rd_last_c;
                    AXIS_TVALID <= 1'b1;
`ifdef OUTPUT_ROW_TUSER_EN
                    AXIS_TUSER  <= rd_user_c;
`endif
                end else begin
                    AXIS_TVALID <= 1'b0;
                    AXIS_TLAST  <= 1'b0;
`ifdef OUTPUT_ROW_TUSER_EN
                    AXIS_TUSER  <= 1'b0;
`endif
                end
            end else if (rd_en_c) begin
                // Head stalled: park the in-flight read in the skid entry.
                sk_data  <= rd_data_c;
                sk_last  <= rd_last_c;
                sk_valid <= 1'b1;
`ifdef OUTPUT_ROW_TUSER_EN
                sk_user  <= rd_user_c;
`endif
            end

            if (pop_c) begin
                if (snd_cnt == C_ADDR_BITS'(DEPTH - 1)) begin
                    state         <= COLLECT;
                    out_mem_ready <= 1'b1;
                end else begin
                    snd_cnt <= snd_cnt + C_ADDR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems: a stream-level model (memory image + expected queue)
// checked every cycle, plus literal expectations on the captured streams.
`timescale 1ns/1ps
module tb_output_mems;

    localparam int unsigned OUTW  = 27;
    localparam int unsigned M     = 7;
    localparam int unsigned N     = 9;
    localparam int unsigned DEPTH = M * N;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int          BUDGET = 400;

    logic            clk = 1'b0;
    logic            reset;
    logic [OUTW-1:0] C_data;
    logic [AW-1:0]   C_addr;
    logic            C_wr_en;
    logic            compute_done;
    logic            out_mem_ready;
    logic [OUTW-1:0] AXIS_TDATA;
    logic            AXIS_TVALID;
    logic            AXIS_TREADY;
    logic            AXIS_TLAST;
`ifdef OUTPUT_ROW_TUSER_EN
    logic            AXIS_TUSER;
`endif

    int errors = 0;
    int checks = 0;

    output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .C_data        (C_data),
        .C_addr        (C_addr),
        .C_wr_en       (C_wr_en),
        .compute_done  (compute_done),
        .out_mem_ready (out_mem_ready),
        .AXIS_TDATA    (AXIS_TDATA),
        .AXIS_TVALID   (AXIS_TVALID),
`ifdef OUTPUT_ROW_TUSER_EN
        .AXIS_TUSER    (AXIS_TUSER),
`endif
        .AXIS_TREADY   (AXIS_TREADY),
        .AXIS_TLAST    (AXIS_TLAST)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Model state
    logic [OUTW-1:0] m_mem [DEPTH];
    logic [OUTW-1:0] exp_q [$];
    logic [OUTW-1:0] got [$];
    bit              m_collect  = 1'b1;
    bit              armed      = 1'b0;
    bit              first_seen = 1'b0;
    int              ncyc       = 0;
    int              done_ncyc  = 0;
    bit              prev_valid = 1'b0;
    bit              prev_ready = 1'b0;
    bit              prev_rst   = 1'b1;
    logic [OUTW-1:0] prev_data  = '0;
    bit              prev_last  = 1'b0;

    // Compare process: check outputs, then apply this cycle's inputs to the model.
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (armed) begin
            chk("out_mem_ready", 64'(out_mem_ready), 64'(m_collect));
            if (!prev_rst && prev_valid && !prev_ready) begin
                chk("stall_tvalid", 64'(AXIS_TVALID), 64'd1);
                chk("stall_tdata", 64'(AXIS_TDATA), 64'(prev_data));
                chk("stall_tlast", 64'(AXIS_TLAST), 64'(prev_last));
            end
            if (m_collect || exp_q.size() == 0) begin
                chk("tvalid_idle", 64'(AXIS_TVALID), 64'd0);
            end else if (!first_seen) begin
                chk("first_tvalid", 64'(AXIS_TVALID), 64'((ncyc - done_ncyc) >= 2));
                if (AXIS_TVALID) first_seen = 1'b1;
            end else begin
                chk("tvalid_hold", 64'(AXIS_TVALID), 64'd1);
            end
            if (AXIS_TVALID && exp_q.size() != 0) begin
                chk("tdata", 64'(AXIS_TDATA), 64'(exp_q[0]));
                chk("tlast", 64'(AXIS_TLAST), 64'(exp_q.size() == 1));
`ifdef OUTPUT_ROW_TUSER_EN
                chk("tuser", 64'(AXIS_TUSER),
                    64'(((DEPTH - exp_q.size()) % N) == (N - 1)));
`endif
            end
            if (!AXIS_TVALID) chk("tlast_idle", 64'(AXIS_TLAST), 64'd0);
        end

        if (reset) begin
            m_collect  = 1'b1;
            first_seen = 1'b0;
            exp_q.delete();
            armed = 1'b1;
        end else if (m_collect) begin
            if (C_wr_en && (int'(C_addr) < DEPTH)) m_mem[C_addr] = C_data;
            if (compute_done) begin
                m_collect  = 1'b0;
                first_seen = 1'b0;
                done_ncyc  = ncyc;
                for (int a = 0; a < DEPTH; a++) exp_q.push_back(m_mem[a]);
            end
        end else if (AXIS_TVALID && AXIS_TREADY && exp_q.size() != 0) begin
            got.push_back(AXIS_TDATA);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_collect = 1'b1;
        end

        prev_valid = AXIS_TVALID;
        prev_ready = AXIS_TREADY;
        prev_data  = AXIS_TDATA;
        prev_last  = AXIS_TLAST;
        prev_rst   = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [OUTW-1:0] d);
        C_wr_en = 1'b1;
        C_addr  = AW'(a);
        C_data  = d;
        tick();
        C_wr_en = 1'b0;
    endtask

    task automatic fill3();
        for (int a = 0; a < DEPTH; a++) wr(a, OUTW'(a * 3));
    endtask

    task automatic pulse_done();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
    endtask

    // Drive TREADY until the model sees the stream finish (or stop_at beats).
    task automatic run_stream(input bit stall, input bit inject, input int stop_at);
        int k;
        k = 0;
        got.delete();
        while (!m_collect && k < BUDGET) begin
            if (stop_at > 0 && got.size() >= stop_at) break;
            AXIS_TREADY = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (inject && k == 3) begin
                C_wr_en = 1'b1; C_addr = AW'(5); C_data = OUTW'(999); compute_done = 1'b1;
            end else begin
                C_wr_en = 1'b0; compute_done = 1'b0;
            end
            tick();
            k++;
        end
        C_wr_en = 1'b0;
        compute_done = 1'b0;
        if (k >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d beats after %0d cycles", got.size(), k);
        end
    endtask

    initial begin
        reset = 1'b1; C_wr_en = 1'b0; C_addr = '0; C_data = '0;
        compute_done = 1'b0; AXIS_TREADY = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_ready", 64'(out_mem_ready), 64'd1);
        chk("reset_tvalid", 64'(AXIS_TVALID), 64'd0);
        chk("reset_tlast", 64'(AXIS_TLAST), 64'd0);
        chk("reset_tdata", 64'(AXIS_TDATA), 64'd0);
        tick();

        // 1: full ramp, TREADY always high
        fill3();
        pulse_done();
        run_stream(1'b0, 1'b0, 0);
        chk("t1_count", 64'(got.size()), 64'd63);
        chk("t1_first", 64'(got[0]), 64'd0);
        chk("t1_mid", 64'(got[10]), 64'd30);
        chk("t1_last", 64'(got[62]), 64'd186);
        repeat (2) tick();

        // 2: same data, TREADY pattern 1,0,0,1
        pulse_done();
        run_stream(1'b1, 1'b0, 0);
        chk("t2_count", 64'(got.size()), 64'd63);
        chk("t2_elem33", 64'(got[33]), 64'd99);
        chk("t2_last", 64'(got[62]), 64'd186);
        repeat (2) tick();

        // 3: negative extremes stored raw
        wr(0, 27'h7FFFFFF);
        wr(1, 27'h4000000);
        pulse_done();
        run_stream(1'b0, 1'b0, 0);
        chk("t3_minus1", 64'(got[0]), 64'h7FFFFFF);
        chk("t3_minpow", 64'(got[1]), 64'h4000000);
        chk("t3_elem2", 64'(got[2]), 64'd6);
        repeat (2) tick();

        // 4: write and done during DRAIN are ignored
        fill3();
        pulse_done();
        run_stream(1'b0, 1'b1, 0);
        chk("t4_pass1_a5", 64'(got[5]), 64'd15);
        chk("t4_pass1_count", 64'(got.size()), 64'd63);
        tick();
        pulse_done();
        run_stream(1'b0, 1'b0, 0);
        chk("t4_pass2_a5", 64'(got[5]), 64'd15);
        repeat (2) tick();

        // 5: reset after the 10th transfer, then refill and full stream
        pulse_done();
        run_stream(1'b0, 1'b0, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_beats_before_reset", 64'(got.size()), 64'd10);
        chk("t5_ready", 64'(out_mem_ready), 64'd1);
        chk("t5_tvalid", 64'(AXIS_TVALID), 64'd0);
        chk("t5_tlast", 64'(AXIS_TLAST), 64'd0);
        tick();
        for (int a = 0; a < DEPTH; a++) wr(a, OUTW'(a + 100));
        pulse_done();
        run_stream(1'b0, 1'b0, 0);
        chk("t5_refill_count", 64'(got.size()), 64'd63);
        chk("t5_refill_last", 64'(got[62]), 64'd162);
        repeat (2) tick();

        // 6: done coincident with the write to 62, plus an out-of-range write
        fill3();
        wr(63, OUTW'(555));
        C_wr_en = 1'b1; C_addr = AW'(62); C_data = OUTW'(77); compute_done = 1'b1;
        tick();
        C_wr_en = 1'b0; compute_done = 1'b0;
        run_stream(1'b0, 1'b0, 0);
        chk("t6_count", 64'(got.size()), 64'd63);
        chk("t6_last", 64'(got[62]), 64'd77);
        chk("t6_prev", 64'(got[61]), 64'd183);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
